// File: rtl/ssd_capture_if.sv
// Scan-bus bundle between the display scanner side and the capture block.
// The scanner side drives seven/segment; the capture side returns the rebuilt frame.
interface ssd_capture_if;
   logic [7:0] seven;
   logic [3:0] segment;
   logic [7:0] disp0;
   logic [7:0] disp1;
   logic [7:0] disp2;
   logic [7:0] disp3;
   logic [3:0] hex0;
   logic [3:0] hex1;
   logic [3:0] hex2;
   logic [3:0] hex3;
   logic [3:0] hex_ok;
   logic       frame_valid;
   logic       frame_strobe;
   logic       scan_err;
   logic       stale;

   modport master (
      output seven, segment,
      input  disp0, disp1, disp2, disp3, hex0, hex1, hex2, hex3, hex_ok,
      input  frame_valid, frame_strobe, scan_err, stale
   );

   modport slave (
      input  seven, segment,
      output disp0, disp1, disp2, disp3, hex0, hex1, hex2, hex3, hex_ok,
      output frame_valid, frame_strobe, scan_err, stale
   );
endinterface

// File: rtl/ssd_capture.sv
// Seven-segment scan-bus receiver: debounces the multiplexed seven/segment pair,
// rebuilds the four digit patterns in order 0..3, decodes them to hex and
// publishes a consistent frame once per scan. Flags stale scans via a timeout.
module ssd_capture #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned FRAME_TIMEOUT = 262144
) (
   input logic            clk,
   input logic            rst_n,
   ssd_capture_if.slave   bus
);

   localparam logic [7:0]  StableM1 = 8'(STABLE_CYCLES - 1);
   localparam logic [23:0] TimeoutW = 24'(FRAME_TIMEOUT);

   typedef enum logic [0:0] {StSync, StCollect} state_e;

   // Returns {match, nibble}; dp is excluded by the caller.
   function automatic logic [4:0] decode(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h7C:   r = 5'h1B;
         7'h39:   r = 5'h1C;
         7'h5E:   r = 5'h1D;
         7'h79:   r = 5'h1E;
         7'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [11:0] cur;
   logic [11:0] samp_q;
   logic [7:0]  run_q, run_d;
   logic        same;
   logic        accept;

   state_e      state_q, state_d;
   logic [1:0]  exp_q, exp_d;
   logic [7:0]  shadow_q [4];
   logic [7:0]  shadow_d [4];
   logic [7:0]  frame    [4];
   logic [1:0]  idx;
   logic        onehot;
   logic        publish;
   logic        err;

   logic [7:0]  disp_q [4];
   logic [3:0]  hex_q  [4];
   logic [3:0]  hex_ok_q;
   logic        fv_q, fv_d;
   logic        strobe_q;
   logic        err_q;
   logic        stale_q, stale_d;
   logic [23:0] tmo_q, tmo_d;

   assign cur = {bus.seven, bus.segment};

   // Stability run counter; acceptance fires only on the edge the run reaches STABLE_CYCLES.
   always_comb begin
      same   = (cur == samp_q);
      run_d  = 8'd1;
      accept = 1'b0;
      if (same) begin
         run_d  = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
         accept = (run_q == StableM1);
      end
   end

   // Sample register and run counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_q <= '0;
         run_q  <= '0;
      end else begin
         samp_q <= cur;
         run_q  <= run_d;
      end
   end

   // One-hot digit select to index; non-one-hot patterns are flagged separately.
   always_comb begin
      onehot = 1'b1;
      idx    = 2'd0;
      unique case (bus.segment)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: onehot = 1'b0;
      endcase
   end

   // Frame assembly FSM: next state, shadow updates, publish and error decisions.
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      shadow_d = shadow_q;
      publish  = 1'b0;
      err      = 1'b0;
      if (accept && (bus.segment != 4'b0000)) begin
         if (!onehot) begin
            err     = 1'b1;
            state_d = StSync;
         end else begin
            unique case (state_q)
               StSync: begin
                  // Mid-scan startup: wait silently for digit 0.
                  if (idx == 2'd0) begin
                     shadow_d[0] = bus.seven;
                     exp_d       = 2'd1;
                     state_d     = StCollect;
                  end
               end
               StCollect: begin
                  if (idx == exp_q) begin
                     shadow_d[idx] = bus.seven;
                     if (idx == 2'd3) begin
                        publish = 1'b1;
                        state_d = StSync;
                     end else begin
                        exp_d = exp_q + 2'd1;
                     end
                  end else if (idx == 2'd0) begin
                     // Early digit 0: restart the frame but still report it.
                     shadow_d[0] = bus.seven;
                     exp_d       = 2'd1;
                     err         = 1'b1;
                  end else begin
                     err     = 1'b1;
                     state_d = StSync;
                  end
               end
               default: state_d = StSync;
            endcase
         end
      end
   end

   // Digit 3 is published straight from the bus so all four land on the same edge.
   always_comb begin
      frame[0] = shadow_q[0];
      frame[1] = shadow_q[1];
      frame[2] = shadow_q[2];
      frame[3] = bus.seven;
   end

   // FSM state, expected index and shadow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSync;
         exp_q   <= 2'd0;
         for (int k = 0; k < 4; k++) shadow_q[k] <= 8'h00;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         for (int k = 0; k < 4; k++) shadow_q[k] <= shadow_d[k];
      end
   end

   // Timeout counter and validity flags; publish takes priority over timeout.
   always_comb begin
      tmo_d   = publish ? 24'd0 : ((tmo_q == 24'hFFFFFF) ? tmo_q : tmo_q + 24'd1);
      stale_d = publish ? 1'b0 : ((tmo_d >= TimeoutW) ? 1'b1 : stale_q);
      fv_d    = publish ? 1'b1 : (stale_d ? 1'b0 : fv_q);
   end

   // Published frame, decode results and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            disp_q[k] <= 8'h00;
            hex_q[k]  <= 4'h0;
         end
         hex_ok_q <= 4'h0;
         fv_q     <= 1'b0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
         stale_q  <= 1'b0;
         tmo_q    <= 24'd0;
      end else begin
         strobe_q <= publish;
         err_q    <= err;
         stale_q  <= stale_d;
         fv_q     <= fv_d;
         tmo_q    <= tmo_d;
         if (publish) begin
            for (int k = 0; k < 4; k++) begin
               disp_q[k]                <= frame[k];
               {hex_ok_q[k], hex_q[k]}  <= decode(frame[k][6:0]);
            end
         end
      end
   end

   assign bus.disp0        = disp_q[0];
   assign bus.disp1        = disp_q[1];
   assign bus.disp2        = disp_q[2];
   assign bus.disp3        = disp_q[3];
   assign bus.hex0         = hex_q[0];
   assign bus.hex1         = hex_q[1];
   assign bus.hex2         = hex_q[2];
   assign bus.hex3         = hex_q[3];
   assign bus.hex_ok       = hex_ok_q;
   assign bus.frame_valid  = fv_q;
   assign bus.frame_strobe = strobe_q;
   assign bus.scan_err     = err_q;
   assign bus.stale        = stale_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: directed scenarios plus randomized scans, every cycle
// compared against a frame-level reference model of the scan protocol.
module tb_ssd_capture;

   localparam int unsigned S = 4;
   localparam int unsigned T = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssd_capture_if bus ();

   ssd_capture #(
      .STABLE_CYCLES (S),
      .FRAME_TIMEOUT (T)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_strobe = 0;
   int n_err = 0;
   int strobe_pos = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model state
   logic [11:0] m_prev;
   int          m_run;
   int          m_want;     // -1 while waiting for digit 0
   logic [7:0]  m_shadow [4];
   logic [7:0]  m_disp [4];
   logic [3:0]  m_hex [4];
   logic [3:0]  m_ok;
   bit          m_pub_ever;
   int          m_since;
   bit          m_strobe;
   bit          m_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, expv);
         $error("comparison %s differs", tag);
      end
   endtask

   function automatic logic [4:0] ref_decode(input logic [7:0] v);
      for (int k = 0; k < 16; k++) if (glyph[k] == v[6:0]) return {1'b1, 4'(k)};
      return 5'h00;
   endfunction

   task automatic model_reset();
      m_prev = '0; m_run = 0; m_want = -1; m_ok = '0;
      m_pub_ever = 0; m_since = 0; m_strobe = 0; m_err = 0;
      for (int k = 0; k < 4; k++) begin
         m_shadow[k] = '0; m_disp[k] = '0; m_hex[k] = '0;
      end
   endtask

   task automatic model_edge(input logic [7:0] sv, input logic [3:0] sg);
      logic [11:0] c;
      int old_run, i;
      bit acc, pub;
      c = {sv, sg};
      old_run = m_run;
      if (c == m_prev) m_run = (m_run < 255) ? m_run + 1 : 255;
      else m_run = 1;
      m_prev = c;
      acc = (m_run == int'(S)) && (old_run != int'(S));
      pub = 0; m_err = 0;
      if (acc && sg != 4'b0000) begin
         if ($countones(sg) > 1) begin
            m_err = 1; m_want = -1;
         end else begin
            i = $clog2(sg);
            if (m_want < 0) begin
               if (i == 0) begin m_shadow[0] = sv; m_want = 1; end
            end else if (i == m_want) begin
               m_shadow[i] = sv;
               if (i == 3) begin pub = 1; m_want = -1; end
               else m_want++;
            end else if (i == 0) begin
               m_shadow[0] = sv; m_want = 1; m_err = 1;
            end else begin
               m_err = 1; m_want = -1;
            end
         end
      end
      m_strobe = pub;
      if (pub) begin
         for (int k = 0; k < 4; k++) begin
            m_disp[k] = m_shadow[k];
            {m_ok[k], m_hex[k]} = ref_decode(m_shadow[k]);
         end
         m_pub_ever = 1; m_since = 0;
      end else if (m_since < 24'hFFFFFF) begin
         m_since++;
      end
   endtask

   function automatic logic [63:0] dut_outs();
      return {8'h00, bus.disp0, bus.disp1, bus.disp2, bus.disp3,
              bus.hex0, bus.hex1, bus.hex2, bus.hex3, bus.hex_ok,
              bus.frame_valid, bus.frame_strobe, bus.scan_err, bus.stale};
   endfunction

   function automatic logic [63:0] model_outs();
      bit st;
      st = (m_since >= int'(T));
      return {8'h00, m_disp[0], m_disp[1], m_disp[2], m_disp[3],
              m_hex[0], m_hex[1], m_hex[2], m_hex[3], m_ok,
              m_pub_ever && !st, m_strobe, m_err, st};
   endfunction

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic step(input logic [7:0] sv, input logic [3:0] sg, output bit strobe_seen);
      bus.seven = sv;
      bus.segment = sg;
      @(posedge clk);
      model_edge(sv, sg);
      #1;
      check("cycle_outputs", dut_outs(), model_outs());
      strobe_seen = bus.frame_strobe;
      if (bus.frame_strobe) n_strobe++;
      if (bus.scan_err) n_err++;
   endtask

   task automatic drive(input logic [7:0] sv, input logic [3:0] sg, input int n);
      bit s;
      strobe_pos = 0;
      for (int i = 0; i < n; i++) begin
         step(sv, sg, s);
         if (s && strobe_pos == 0) strobe_pos = i + 1;
      end
   endtask

   task automatic frame4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
      drive(d0, 4'b0001, 10);
      drive(d1, 4'b0010, 10);
      drive(d2, 4'b0100, 10);
      drive(d3, 4'b1000, 10);
   endtask

   function automatic logic [7:0] rand_digit();
      if ($urandom_range(0, 3) != 0) return {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
      return 8'($urandom);
   endfunction

   initial begin
      logic [3:0] sg;
      logic [7:0] v;
      bus.seven = 8'h00;
      bus.segment = 4'h0;
      model_reset();
      #3;
      check("reset_outputs", dut_outs(), 64'h0);
      #20 rst_n = 1'b1;

      // Clean frame
      n_strobe = 0; n_err = 0;
      frame4(8'h3F, 8'h06, 8'h5B, 8'h4F);
      check("clean_strobe_count", 64'(n_strobe), 64'd1);
      check("clean_strobe_latency", 64'(strobe_pos), 64'd4);
      check("clean_disp", {bus.disp0, bus.disp1, bus.disp2, bus.disp3}, 64'h3F065B4F);
      check("clean_hex", {bus.hex0, bus.hex1, bus.hex2, bus.hex3}, 64'h0123);
      check("clean_hex_ok", 64'(bus.hex_ok), 64'hF);
      check("clean_valid", 64'(bus.frame_valid), 64'd1);

      // Glitch inside digit 1
      n_strobe = 0; n_err = 0;
      drive(8'h66, 4'b0001, 10);
      drive(8'h06, 4'b0010, 3);
      drive(8'hFF, 4'b0010, 3);
      drive(8'h06, 4'b0010, 6);
      drive(8'h7D, 4'b0100, 10);
      drive(8'h07, 4'b1000, 10);
      check("glitch_disp1", 64'(bus.disp1), 64'h06);
      check("glitch_no_err", 64'(n_err), 64'd0);
      check("glitch_strobe", 64'(n_strobe), 64'd1);

      // Protocol errors
      n_strobe = 0; n_err = 0;
      drive(8'h3F, 4'b0011, 10);
      check("multi_bit_err", 64'(n_err), 64'd1);
      drive(8'h3F, 4'b0001, 10);
      drive(8'h5B, 4'b0100, 10);
      check("order_err", 64'(n_err), 64'd2);
      drive(8'h4F, 4'b1000, 10);
      check("order_no_publish", 64'(n_strobe), 64'd0);
      frame4(8'h7F, 8'h6F, 8'h77, 8'h7C);
      check("order_recover", 64'(n_strobe), 64'd1);

      // Decode: dp-only digit
      frame4(8'h39, 8'h5E, 8'h80, 8'h71);
      check("decode_hex2", 64'(bus.hex2), 64'h0);
      check("decode_hex_ok", 64'(bus.hex_ok), 64'b1011);

      // Timeout, then recovery
      frame4(8'h06, 8'h5B, 8'h4F, 8'h66);
      drive(8'h3F, 4'b0001, T);
      check("timeout_stale", 64'(bus.stale), 64'd1);
      check("timeout_valid", 64'(bus.frame_valid), 64'd0);
      check("timeout_disp_hold", {bus.disp0, bus.disp1, bus.disp2, bus.disp3}, 64'h065B4F66);
      drive(8'h06, 4'b0010, 10);
      drive(8'h5B, 4'b0100, 10);
      drive(8'h4F, 4'b1000, 10);
      check("recover_stale", 64'(bus.stale), 64'd0);
      check("recover_valid", 64'(bus.frame_valid), 64'd1);

      // Reset mid-frame
      drive(8'h6D, 4'b0001, 10);
      drive(8'h7D, 4'b0010, 10);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", dut_outs(), 64'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      n_strobe = 0;
      drive(8'h5B, 4'b0100, 10);
      drive(8'h4F, 4'b1000, 10);
      check("reset_no_publish", 64'(n_strobe), 64'd0);
      frame4(8'h3F, 8'h06, 8'h5B, 8'h4F);
      check("reset_then_frame", 64'(n_strobe), 64'd1);

      // Randomized scans, checked cycle by cycle against the model
      for (int f = 0; f < 40; f++) begin
         for (int k = 0; k < 4; k++) begin
            sg = 4'(1 << k);
            case ($urandom_range(0, 15))
               0: sg = 4'(1 << $urandom_range(0, 3));
               1: sg = 4'b0000;
               2: sg = 4'($urandom);
               default: ;
            endcase
            v = rand_digit();
            if ($urandom_range(0, 4) == 0) begin
               drive(v, sg, $urandom_range(1, S - 1));
               drive(8'($urandom), sg, $urandom_range(1, S - 1));
            end
            drive(v, sg, S + $urandom_range(0, 6));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
